// File: rtl/inst_mem_loader_pkg.sv
// Shared constants for the instruction-memory loader: default widths,
// controller state encodings and a small state-decode helper.
package inst_mem_loader_pkg;

    // Default widths for the GPP core's instruction path.
    localparam int DEF_SA_WIDTH = 8;   // fetch address width
    localparam int DEF_D_WIDTH  = 32;  // instruction word width
    localparam int DEF_SL_WIDTH = 16;  // instruction words in the store

    // Controller states, explicitly encoded on 3 bits.
    typedef enum logic [2:0] {
        S_LOAD = 3'd0,  // accepting program words from the load stream
        S_FILL = 3'd1,  // zero-filling the words the program did not cover
        S_ARM  = 3'd2,  // one last reset cycle for the core after the final write
        S_RUN  = 3'd3,  // core running, fetches served
        S_HALT = 3'd4   // core reported Done, fetches still served
    } state_t;

    // The core is held in reset while the program store is being built.
    function automatic logic holds_core(input state_t s);
        return (s == S_LOAD) || (s == S_FILL) || (s == S_ARM);
    endfunction

endpackage

// File: rtl/inst_mem_loader_ram.sv
// Single-port synchronous instruction RAM. One shared address: writes come
// from the loader/fill path, reads from the core's fetch path; the two never
// overlap in time, so no read-during-write behaviour needs defining.
module inst_ram #(
    parameter int DEPTH   = 16,
    parameter int D_WIDTH = 32,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               we,
    input  logic               re,
    input  logic               rd_zero,
    input  logic [AW-1:0]      addr,
    input  logic [D_WIDTH-1:0] wdata,
    output logic [D_WIDTH-1:0] rdata
);

    logic [D_WIDTH-1:0] mem [DEPTH];

    // Storage write; the loader always rewrites every word before the core runs.
    // NOTE: the array has no reset branch so it maps onto block RAM; clearing it
    // would cost DEPTH cycles or a flop array, and every word is rewritten anyway.
    always_ff @(posedge Clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Registered read port; an out-of-range fetch returns zero instead of a word.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rdata <= '0;
        end else if (rd_zero) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/inst_mem_loader.sv
// Instruction store in front of the GPP core: loads a program from a
// valid/ready stream, zero-fills the rest, releases the core from reset,
// serves its fetches with one cycle of latency and tracks its Done flag.
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int SA_WIDTH = DEF_SA_WIDTH,
    parameter int D_WIDTH  = DEF_D_WIDTH,
    parameter int DEPTH    = DEF_SL_WIDTH,
    parameter int CW       = $clog2(DEPTH) + 1
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [D_WIDTH-1:0]  Ld_Data,
    input  logic                Ld_Valid,
    input  logic                Ld_Last,
    output logic                Ld_Ready,
    input  logic                Reload,
    input  logic [SA_WIDTH-1:0] Addr,
    input  logic                En,
    input  logic                RW,
    output logic [D_WIDTH-1:0]  Data,
    input  logic                Done,
    output logic                Cpu_Rst,
    output logic                Halted,
    output logic [CW-1:0]       Word_Cnt,
    output logic                Err
);

    localparam int                AW       = $clog2(DEPTH);
    localparam logic [CW-1:0]     LAST_PTR = CW'(DEPTH - 1);
    localparam logic [SA_WIDTH:0] DEPTH_A  = (SA_WIDTH + 1)'(DEPTH);

    state_t             state;
    state_t             state_nx;
    logic [CW-1:0]      wr_ptr;
    logic [CW-1:0]      wr_ptr_nx;
    logic [CW-1:0]      cnt_nx;
    logic               err_nx;

    logic               ram_we;
    logic               ram_re;
    logic               ram_zero;
    logic [AW-1:0]      ram_addr;
    logic [D_WIDTH-1:0] ram_wdata;

    // State register.
    // NOTE: every clocked block uses non-blocking assignments so all flops
    // sample their inputs from the same edge, independent of block order.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= S_LOAD;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state, write-pointer, RAM-control and error decode.
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nx  = state;
        wr_ptr_nx = wr_ptr;
        cnt_nx    = Word_Cnt;
        err_nx    = Err;
        ram_we    = 1'b0;
        ram_wdata = '0;
        ram_re    = 1'b0;
        ram_zero  = 1'b0;

        case (state)
            S_LOAD: begin
                if (Ld_Valid && Ld_Ready) begin
                    ram_we    = 1'b1;
                    ram_wdata = Ld_Data;
                    wr_ptr_nx = wr_ptr + CW'(1);
                    cnt_nx    = Word_Cnt + CW'(1);
                    // A beat into the last word fills the store; no zero-fill.
                    if (wr_ptr == LAST_PTR) begin
                        state_nx = S_ARM;
                    end else if (Ld_Last) begin
                        state_nx = S_FILL;
                    end
                end
            end

            S_FILL: begin
                // Unloaded words become 0, which the core executes as a NOP.
                ram_we    = 1'b1;
                ram_wdata = '0;
                wr_ptr_nx = wr_ptr + CW'(1);
                if (wr_ptr == LAST_PTR) begin
                    state_nx = S_ARM;
                end
            end

            S_ARM: begin
                state_nx = S_RUN;
            end

            S_RUN, S_HALT: begin
                if (En) begin
                    if (RW) begin
                        // The store is read-only to the core.
                        err_nx = 1'b1;
                    end else if ({1'b0, Addr} < DEPTH_A) begin
                        ram_re = 1'b1;
                    end else begin
                        ram_zero = 1'b1;
                        err_nx   = 1'b1;
                    end
                end

                if ((state == S_RUN) && Done) begin
                    state_nx = S_HALT;
                end else if ((state == S_HALT) && Reload) begin
                    state_nx  = S_LOAD;
                    wr_ptr_nx = '0;
                    cnt_nx    = '0;
                end
            end

            default: begin
                state_nx = S_LOAD;
            end
        endcase
    end

    // Shared address: the write pointer while building, the fetch address otherwise.
    assign ram_addr = ram_we ? wr_ptr[AW-1:0] : Addr[AW-1:0];

    // Registered outputs and loader bookkeeping, decoded from the next state
    // so each output lines up with the state it describes.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr   <= '0;
            Word_Cnt <= '0;
            Err      <= 1'b0;
            Ld_Ready <= 1'b1;
            Cpu_Rst  <= 1'b1;
            Halted   <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_nx;
            Word_Cnt <= cnt_nx;
            Err      <= err_nx;
            Ld_Ready <= (state_nx == S_LOAD);
            Cpu_Rst  <= holds_core(state_nx);
            Halted   <= (state_nx == S_HALT);
        end
    end

    inst_ram #(
        .DEPTH   (DEPTH),
        .D_WIDTH (D_WIDTH),
        .AW      (AW)
    ) u_inst_ram (
        .Clk     (Clk),
        .Rst     (Rst),
        .we      (ram_we),
        .re      (ram_re),
        .rd_zero (ram_zero),
        .addr    (ram_addr),
        .wdata   (ram_wdata),
        .rdata   (Data)
    );

endmodule
